// File: rtl/lustre_unsigned_divmod_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM encoding and counter sizing.
package lustre_unsigned_divmod_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'd0,
    STATE_RUN  = 2'd1,
    STATE_DONE = 2'd2
  } state_t;

  // Iteration counter must hold 0..n-1 with headroom, matching $clog2(n+1).
  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lustre_unsigned_divmod_arith.sv
// Arithmetic leaf cells used by the divider: unsigned less-than and a carry-in adder.
module lustre_unsigned_lt #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  output logic         res
);

  assign res = (lhs < rhs);

endmodule

module internal_lustre_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  input  logic         carry_in,
  output logic [N-1:0] sum
);

  // Wraps modulo 2^N; callers build subtraction as lhs + ~rhs + 1.
  assign sum = lhs + rhs + N'(carry_in);

endmodule

// File: rtl/lustre_unsigned_divmod.sv
// Restoring unsigned divider: one quotient bit per cycle, valid/ready on both sides.
module lustre_unsigned_divmod
  import lustre_unsigned_divmod_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem,
  output logic         div_by_zero
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned CW = count_width(N);

  state_t        state;
  logic [N-1:0]  dividend;
  logic [N-1:0]  divisor;
  logic [N-1:0]  prem;
  logic [CW-1:0] count;

  logic [W-1:0]  trial;
  logic [W-1:0]  diff;
  logic [N-1:0]  prem_next;
  logic          lt;
  logic          unused_diff_msb;

  // Partial remainder is N+1 bits wide on the datapath; its stored MSB is always 0.
  assign trial = {prem, dividend[N-1]};

  lustre_unsigned_lt #(.N(W)) u_lt (
    .lhs (trial),
    .rhs ({1'b0, divisor}),
    .res (lt)
  );

  internal_lustre_adder #(.N(W)) u_sub (
    .lhs      (trial),
    .rhs      (~{1'b0, divisor}),
    .carry_in (1'b1),
    .sum      (diff)
  );

  assign prem_next       = lt ? trial[N-1:0] : diff[N-1:0];
  assign unused_diff_msb = diff[N];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= STATE_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      dividend    <= '0;
      divisor     <= '0;
      prem        <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (in_valid && in_ready) begin
            dividend <= lhs;
            divisor  <= rhs;
            prem     <= '0;
            count    <= '0;
            in_ready <= 1'b0;
            if (rhs == '0) begin
              quot        <= '1;
              rem         <= lhs;
              div_by_zero <= 1'b1;
              state       <= STATE_DONE;
            end else begin
              quot        <= '0;
              div_by_zero <= 1'b0;
              state       <= STATE_RUN;
            end
          end
        end
        STATE_RUN: begin
          prem     <= prem_next;
          quot     <= N'({quot, ~lt});
          dividend <= dividend << 1;
          count    <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            rem   <= prem_next;
            state <= STATE_DONE;
          end
        end
        STATE_DONE: begin
          out_valid <= 1'b1;
          // Consumer must have seen out_valid before the result is released.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lustre_unsigned_divmod.sv
// Randomised and directed checks of lustre_unsigned_divmod (N=8) against an arithmetic model.
module tb_lustre_unsigned_divmod;

  localparam int unsigned N = 8;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] lhs;
  logic [N-1:0] rhs;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quot;
  logic [N-1:0] rem;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  lustre_unsigned_divmod #(.N(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lhs         (lhs),
    .rhs         (rhs),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low after out_valid rises.
  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
    int          cyc;
    bit          dz;
    logic [31:0] eq;
    logic [31:0] er;
    dz = (b == 0);
    eq = dz ? 32'((1 << N) - 1) : 32'(a) / 32'(b);
    er = dz ? 32'(a) : 32'(a) % 32'(b);

    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);

    out_ready = (hold == 0);
    in_valid  = 1'b1;
    lhs       = a;
    rhs       = b;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lhs      = ~a;
    rhs      = ~b;
    check("ready_low_after_accept", 32'(in_ready), 32'd0);

    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("latency", 32'(cyc), dz ? 32'd1 : 32'(N + 1));
    check("quot", 32'(quot), eq);
    check("rem", 32'(rem), er);
    check("div_by_zero", 32'(div_by_zero), 32'(dz));
    if (!dz) begin
      check("inv_sum", 32'(quot) * 32'(b) + 32'(rem), 32'(a));
      check("inv_rem_lt", 32'(rem < b), 32'd1);
    end

    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        in_valid = 1'b1;
        lhs      = 8'd9;
        rhs      = 8'd4;
      end
      @(posedge clock); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_quot", 32'(quot), eq);
      check("hold_rem", 32'(rem), er);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    check("valid_cleared", 32'(out_valid), 32'd0);
    check("ready_restored", 32'(in_ready), 32'd1);
    check("quot_kept", 32'(quot), eq);
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    lhs       = '0;
    rhs       = '0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quot), 32'd0);
    check("rst_rem", 32'(rem), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    do_div(8'd100, 8'd7, 0);
    do_div(8'd255, 8'd1, 0);
    do_div(8'd5, 8'd200, 0);
    do_div(8'd42, 8'd0, 0);
    do_div(8'd200, 8'd10, 5);

    // Asynchronous reset in the fourth RUN cycle discards the division.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    lhs       = 8'd77;
    rhs       = 8'd3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("midrun_out_valid", 32'(out_valid), 32'd0);
    check("midrun_quot", 32'(quot), 32'd0);
    check("midrun_rem", 32'(rem), 32'd0);
    check("midrun_in_ready", 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_div(8'd77, 8'd3, 0);

    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      case (i % 8)
        0: b = 8'd0;
        1: a = 8'd0;
        2: b = a;
        3: begin
          a = 8'($urandom_range(0, 254));
          b = 8'($urandom_range(32'(a) + 1, 255));
        end
        default: ;
      endcase
      do_div(a, b, (i % 16 == 5) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
